core_c1_ifu_pf: RTL and testbench
=================================

// Module: core_c1_ifu_pf
// PURPOSE
//  Prefetching instruction fetch unit for the c1 rv32i core; generalises the single-slot IFU.
//  Keeps up to MAX_OUTST fetches in flight to the BIU and buffers returned words in a FIFO_DEPTH queue.
//  Handles branch/exception redirect by discarding stale in-flight responses.
//  Sits between the BIU (valid/ready request, in-order response) and the IDU/EXU (valid/ready issue).
// PARAMETERS
//  XLEN        32       address/instruction width
//  FIFO_DEPTH  4        instruction buffer entries, power of 2, >=2
//  MAX_OUTST   2        max in-flight BIU requests, >=1
//  RESET_PC    32'h0    fetch address after reset
// PORTS
//  clk             in   1     clock, all logic on rising edge
//  rst             in   1     synchronous reset, active-high
//  i_flush_b       in   1     branch redirect request
//  i_flush_addr_b  in   XLEN  branch target
//  i_flush_e       in   1     exception redirect request, priority over branch
//  i_flush_addr_e  in   XLEN  exception vector
//  o_req_valid     out  1     fetch request to BIU
//  o_req_addr      out  XLEN  fetch address (word aligned)
//  i_req_ready     in   1     BIU accepts request
//  i_rsp_valid     in   1     BIU response, in request order, no back-pressure
//  i_rsp_data      in   XLEN  fetched word
//  i_rsp_err       in   1     bus error on this fetch
//  o_inst_valid    out  1     FIFO head valid to decode
//  o_inst          out  XLEN  instruction word
//  o_inst_pc       out  XLEN  PC of o_inst
//  o_inst_err      out  1     fetch fault for this entry
//  i_inst_ready    in   1     decode consumes head
//  o_fifo_level    out  $clog2(FIFO_DEPTH)+1  buffered entries
// BEHAVIOUR
//  Reset: o_req_valid=0, o_req_addr=RESET_PC, o_inst_valid=0, o_inst_err=0, o_fifo_level=0, FSM=IDLE.
//  FSM: IDLE -(1 cycle)-> RUN; RUN -(accepted rsp with err, not dropped)-> HALT; any state -(flush)-> RUN.
//  req_pc increments by 4 per request handshake (o_req_valid & i_req_ready), wraps mod 2^XLEN.
//  o_req_valid = (FSM==RUN) & ~flush & (outst<MAX_OUTST) & (outst-drop+level < FIFO_DEPTH); conservative, no pop credit.
//  o_req_valid/o_req_addr hold stable while o_req_valid=1 & ~i_req_ready, unless flushed.
//  outst: +1 on req handshake, -1 on i_rsp_valid; both same cycle -> unchanged.
//  rsp_pc tracks PC of next expected response; +4 per response kept.
//  Response with drop>0: discarded, drop-1. Otherwise push {rsp_pc,data,err} into FIFO.
//  FIFO never overflows by credit rule; assertion fires if push with level==FIFO_DEPTH.
//  Output latency: response to o_inst_valid = 1 cycle (registered FIFO, no bypass).
//  Flush (i_flush_e | i_flush_b): target = e ? addr_e : addr_b; req_pc, rsp_pc <= target;
//    FIFO cleared (pop same cycle ignored); drop <= outst - i_rsp_valid; no request issued this cycle;
//    o_inst_valid=0 next cycle; response arriving same cycle as flush is discarded.
//  Target addr[1:0] forced to 0 (misalignment checked upstream).
//  HALT: no new requests; buffered entries (incl. faulted) still drain; o_inst_err=1 on faulted entry.
//  Reset mid-transfer: all counters cleared; BIU must also be reset (responses after reset undefined).
// STRUCTURE
//  core_c1_defines.vh: XLEN, RESET_PC default, FSM state encodings (IDLE/RUN/HALT).
//  Sub-module core_c1_sync_fifo (WIDTH=2*XLEN+1, DEPTH=FIFO_DEPTH, sync clear, level output).
//  Top holds FSM, req_pc/rsp_pc, outst/drop counters, request gating.
// TESTING
//  T1 reset, i_req_ready=1, rsp 1-cycle latency -> req addrs 0,4,8..; o_inst_pc 0,4,8 in order, no gaps once full.
//  T2 i_inst_ready=0 -> exactly FIFO_DEPTH=4 entries buffered, o_req_valid drops, level=4; release -> resumes.
//  T3 2 in flight, flush_b addr 0x100 -> both stale rsps dropped; first o_inst_pc=0x100.
//  T4 flush_b 0x100 and flush_e 0x200 same cycle -> next req addr 0x200.
//  T5 rsp err on pc 0x8 -> o_inst_err=1 at pc 0x8, no further reqs until flush_e 0x40 -> fetch 0x40.
//  T6 i_req_ready=0 for 5 cycles -> o_req_addr stable; rst=1 mid-stream -> all outputs to reset values next cycle.

Source files
------------

// File: rtl/core_c1_ifu_pf_pkg.sv
// rtl/core_c1_ifu_pf_pkg.sv - shared types and defaults for the c1 prefetching fetch unit
package core_c1_ifu_pf_pkg;

    localparam int XLEN_DEF = 32;
    localparam logic [XLEN_DEF-1:0] RESET_PC_DEF = '0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } ifu_state_e;

endpackage

// File: rtl/core_c1_ifu_pf_sync_fifo.sv
// rtl/core_c1_ifu_pf_sync_fifo.sv - registered-head sync FIFO with clear and level output
module core_c1_ifu_pf_sync_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic                       head_valid,
    output logic [WIDTH-1:0]           head_data,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    count;
    logic             full;
    logic             push_ok;
    logic             pop_ok;

    assign full       = (count == LW'(DEPTH));
    assign push_ok    = push & ~full & ~clear;
    assign pop_ok     = pop & (count != '0) & ~clear;
    assign head_valid = (count != '0);
    assign head_data  = mem[rd_ptr];
    assign level      = count;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

    // The fetch credit rule upstream must make this unreachable.
    always_ff @(posedge clk) begin
        if (!rst && !clear) begin
            assert (!(push && full));
        end
    end

endmodule

// File: rtl/core_c1_ifu_pf.sv
// rtl/core_c1_ifu_pf.sv - prefetching IFU: multiple BIU fetches in flight, buffered issue, redirect drop
module core_c1_ifu_pf
    import core_c1_ifu_pf_pkg::*;
#(
    parameter int              XLEN       = XLEN_DEF,
    parameter int              FIFO_DEPTH = 4,
    parameter int              MAX_OUTST  = 2,
    parameter logic [XLEN-1:0] RESET_PC   = XLEN'(RESET_PC_DEF)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_flush_b,
    input  logic [XLEN-1:0]               i_flush_addr_b,
    input  logic                          i_flush_e,
    input  logic [XLEN-1:0]               i_flush_addr_e,
    output logic                          o_req_valid,
    output logic [XLEN-1:0]               o_req_addr,
    input  logic                          i_req_ready,
    input  logic                          i_rsp_valid,
    input  logic [XLEN-1:0]               i_rsp_data,
    input  logic                          i_rsp_err,
    output logic                          o_inst_valid,
    output logic [XLEN-1:0]               o_inst,
    output logic [XLEN-1:0]               o_inst_pc,
    output logic                          o_inst_err,
    input  logic                          i_inst_ready,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);

    localparam int OW = $clog2(MAX_OUTST + 1);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int EW = 2 * XLEN + 1;

    ifu_state_e      state_q;
    ifu_state_e      state_d;
    logic [XLEN-1:0] req_pc_q;
    logic [XLEN-1:0] rsp_pc_q;
    logic [OW-1:0]   outst_q;
    logic [OW-1:0]   drop_q;

    logic            flush;
    logic [XLEN-1:0] flush_sel;
    logic [XLEN-1:0] flush_tgt;
    logic            req_hs;
    logic            rsp_keep;
    logic            inst_pop;
    logic            credit_ok;
    logic [EW-1:0]   fifo_head;
    logic [LW-1:0]   fifo_level;

    assign flush     = i_flush_e | i_flush_b;
    assign flush_sel = i_flush_e ? i_flush_addr_e : i_flush_addr_b;
    assign flush_tgt = {flush_sel[XLEN-1:2], 2'b00};
    assign req_hs    = o_req_valid & i_req_ready;
    assign rsp_keep  = i_rsp_valid & ~flush & (drop_q == '0);
    assign inst_pop  = o_inst_valid & i_inst_ready & ~flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = ST_RUN;
            ST_RUN:  if (rsp_keep && i_rsp_err) state_d = ST_HALT;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
        if (flush) begin
            state_d = ST_RUN;
        end
    end

    // Credit counts live fetches plus buffered words; a same-cycle pop is not credited.
    always_comb begin
        credit_ok   = (32'(outst_q) - 32'(drop_q) + 32'(fifo_level)) < 32'(FIFO_DEPTH);
        o_req_valid = (state_q == ST_RUN) & ~flush
                    & (32'(outst_q) < 32'(MAX_OUTST)) & credit_ok;
    end

    assign o_req_addr = req_pc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            req_pc_q <= RESET_PC;
            rsp_pc_q <= RESET_PC;
            outst_q  <= '0;
            drop_q   <= '0;
        end else begin
            case ({req_hs, i_rsp_valid})
                2'b10:   outst_q <= outst_q + OW'(1);
                2'b01:   outst_q <= outst_q - OW'(1);
                default: outst_q <= outst_q;
            endcase
            if (flush) begin
                req_pc_q <= flush_tgt;
                rsp_pc_q <= flush_tgt;
                drop_q   <= outst_q - OW'(i_rsp_valid);
            end else begin
                if (req_hs) begin
                    req_pc_q <= req_pc_q + XLEN'(4);
                end
                if (i_rsp_valid) begin
                    if (drop_q != '0) begin
                        drop_q <= drop_q - OW'(1);
                    end else begin
                        rsp_pc_q <= rsp_pc_q + XLEN'(4);
                    end
                end
            end
        end
    end

    core_c1_ifu_pf_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .clear      (flush),
        .push       (rsp_keep),
        .push_data  ({rsp_pc_q, i_rsp_data, i_rsp_err}),
        .pop        (inst_pop),
        .head_valid (o_inst_valid),
        .head_data  (fifo_head),
        .level      (fifo_level)
    );

    assign o_inst_pc    = fifo_head[EW-1 -: XLEN];
    assign o_inst       = fifo_head[XLEN:1];
    assign o_inst_err   = o_inst_valid & fifo_head[0];
    assign o_fifo_level = fifo_level;

endmodule

// File: tb/tb_core_c1_ifu_pf.sv
// tb/tb_core_c1_ifu_pf.sv - directed and randomized bench for core_c1_ifu_pf with a BIU/issue reference model
module tb_core_c1_ifu_pf;

    localparam int DEPTH = 4;
    localparam int MAXO  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_flush_b = 1'b0;
    logic [31:0] i_flush_addr_b = '0;
    logic        i_flush_e = 1'b0;
    logic [31:0] i_flush_addr_e = '0;
    logic        o_req_valid;
    logic [31:0] o_req_addr;
    logic        i_req_ready = 1'b0;
    logic        i_rsp_valid = 1'b0;
    logic [31:0] i_rsp_data = '0;
    logic        i_rsp_err = 1'b0;
    logic        o_inst_valid;
    logic [31:0] o_inst;
    logic [31:0] o_inst_pc;
    logic        o_inst_err;
    logic        i_inst_ready = 1'b0;
    logic [2:0]  o_fifo_level;

    core_c1_ifu_pf dut (
        .clk            (clk),
        .rst            (rst),
        .i_flush_b      (i_flush_b),
        .i_flush_addr_b (i_flush_addr_b),
        .i_flush_e      (i_flush_e),
        .i_flush_addr_e (i_flush_addr_e),
        .o_req_valid    (o_req_valid),
        .o_req_addr     (o_req_addr),
        .i_req_ready    (i_req_ready),
        .i_rsp_valid    (i_rsp_valid),
        .i_rsp_data     (i_rsp_data),
        .i_rsp_err      (i_rsp_err),
        .o_inst_valid   (o_inst_valid),
        .o_inst         (o_inst),
        .o_inst_pc      (o_inst_pc),
        .o_inst_err     (o_inst_err),
        .i_inst_ready   (i_inst_ready),
        .o_fifo_level   (o_fifo_level)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int epoch; int due; logic err; } biu_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; logic err; } ent_t;

    biu_t        biu_q[$];
    ent_t        buf_q[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          epoch = 0;
    int          consumed = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    bit          idle = 1'b1;
    bit          halted = 1'b0;
    bit          rand_err = 1'b0;
    bit          await_first = 1'b1;
    logic [31:0] next_req = '0;
    logic [31:0] first_pc = 32'hDEAD_BEEF;
    logic [31:0] err_pc = 32'hDEAD_BEEF;
    logic [31:0] err_addr = 32'hFFFF_FFFF;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    function automatic int cur_pending();
        int n = 0;
        foreach (biu_q[i]) if (biu_q[i].epoch == epoch) n++;
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: act as BIU, check the DUT against the model, then advance the model.
    task automatic tick();
        logic        flush, hs, pop, rsp, exp_rv;
        logic [31:0] tgt;
        biu_t        e;
        ent_t        f;
        hs = 1'b0;
        pop = 1'b0;
        if (!rst && biu_q.size() > 0 && biu_q[0].due <= cyc) begin
            i_rsp_valid = 1'b1;
            i_rsp_data  = memfn(biu_q[0].addr);
            i_rsp_err   = biu_q[0].err;
        end else begin
            i_rsp_valid = 1'b0;
            i_rsp_data  = $urandom;
            i_rsp_err   = 1'($urandom_range(0, 1));
        end
        #1;
        flush = i_flush_b | i_flush_e;
        tgt   = i_flush_e ? i_flush_addr_e : i_flush_addr_b;
        rsp   = i_rsp_valid;
        if (!rst) begin
            exp_rv = !idle && !halted && !flush && (biu_q.size() < MAXO)
                   && (cur_pending() + buf_q.size() < DEPTH);
            chk("req_valid", 32'(o_req_valid), 32'(exp_rv));
            chk("req_addr", o_req_addr, next_req);
            chk("fifo_level", 32'(o_fifo_level), 32'(buf_q.size()));
            chk("inst_valid", 32'(o_inst_valid), 32'(buf_q.size() != 0));
            if (buf_q.size() != 0) begin
                chk("inst_pc", o_inst_pc, buf_q[0].pc);
                chk("inst_data", o_inst, buf_q[0].data);
                chk("inst_err", 32'(o_inst_err), 32'(buf_q[0].err));
            end
            hs  = o_req_valid & i_req_ready;
            pop = o_inst_valid & i_inst_ready;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            biu_q.delete();
            buf_q.delete();
            idle = 1'b1;
            halted = 1'b0;
            await_first = 1'b1;
            next_req = '0;
            chk("rst_req_valid", 32'(o_req_valid), 32'd0);
            chk("rst_req_addr", o_req_addr, 32'h0);
            chk("rst_inst_valid", 32'(o_inst_valid), 32'd0);
            chk("rst_inst_err", 32'(o_inst_err), 32'd0);
            chk("rst_level", 32'(o_fifo_level), 32'd0);
        end else begin
            if (rsp) e = biu_q.pop_front();
            if (flush) begin
                epoch++;
                buf_q.delete();
                halted = 1'b0;
                await_first = 1'b1;
                next_req = {tgt[31:2], 2'b00};
            end else begin
                if (pop && buf_q.size() != 0) begin
                    f = buf_q.pop_front();
                    consumed++;
                    if (await_first) begin
                        first_pc = f.pc;
                        await_first = 1'b0;
                    end
                    if (f.err) err_pc = f.pc;
                end
                if (rsp && e.epoch == epoch) begin
                    buf_q.push_back('{pc: e.addr, data: memfn(e.addr), err: e.err});
                    if (e.err) halted = 1'b1;
                end
                if (hs) begin
                    e.addr  = next_req;
                    e.epoch = epoch;
                    e.due   = cyc + $urandom_range(lat_min, lat_max) - 1;
                    e.err   = (next_req == err_addr) || (rand_err && $urandom_range(0, 39) == 0);
                    biu_q.push_back(e);
                    next_req = next_req + 32'd4;
                end
            end
            idle = 1'b0;
        end
    endtask

    initial begin
        int          c0;
        logic [31:0] held;

        // Reset
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // T1: streaming fetch from reset, ready BIU, 1-cycle latency
        i_req_ready = 1'b1;
        i_inst_ready = 1'b1;
        repeat (20) tick();
        chk("t1_first_pc", first_pc, 32'h0);
        chk("t1_no_gaps", 32'(consumed >= 16), 32'd1);

        // T2: decode stalls, buffer fills to depth, then resumes
        i_inst_ready = 1'b0;
        repeat (10) tick();
        chk("t2_level_full", 32'(o_fifo_level), 32'd4);
        chk("t2_req_stopped", 32'(o_req_valid), 32'd0);
        c0 = consumed;
        i_inst_ready = 1'b1;
        repeat (10) tick();
        chk("t2_resume", 32'(consumed - c0 >= 8), 32'd1);

        // T3: branch redirect with fetches in flight
        lat_min = 3;
        lat_max = 3;
        repeat (4) tick();
        i_flush_b = 1'b1;
        i_flush_addr_b = 32'h100;
        tick();
        i_flush_b = 1'b0;
        repeat (12) tick();
        chk("t3_first_pc", first_pc, 32'h100);

        // T4: exception wins over simultaneous branch
        lat_min = 1;
        lat_max = 1;
        i_flush_b = 1'b1;
        i_flush_addr_b = 32'h100;
        i_flush_e = 1'b1;
        i_flush_addr_e = 32'h200;
        tick();
        i_flush_b = 1'b0;
        i_flush_e = 1'b0;
        chk("t4_req_addr", o_req_addr, 32'h200);
        repeat (8) tick();
        chk("t4_first_pc", first_pc, 32'h200);

        // T5: bus error halts fetch until exception redirect
        rst = 1'b1;
        tick();
        rst = 1'b0;
        err_addr = 32'h8;
        repeat (15) tick();
        chk("t5_err_pc", err_pc, 32'h8);
        chk("t5_halted", 32'(o_req_valid), 32'd0);
        err_addr = 32'hFFFF_FFFF;
        i_flush_e = 1'b1;
        i_flush_addr_e = 32'h40;
        tick();
        i_flush_e = 1'b0;
        repeat (8) tick();
        chk("t5_refetch_pc", first_pc, 32'h40);

        // Unaligned target near the top of the address space wraps
        i_flush_b = 1'b1;
        i_flush_addr_b = 32'hFFFF_FFFB;
        tick();
        i_flush_b = 1'b0;
        repeat (8) tick();
        chk("wrap_first_pc", first_pc, 32'hFFFF_FFF8);

        // T6: BIU stall holds the request, then reset mid-stream
        i_req_ready = 1'b0;
        repeat (2) tick();
        held = o_req_addr;
        repeat (5) begin
            tick();
            chk("t6_addr_stable", o_req_addr, held);
            chk("t6_valid_held", 32'(o_req_valid), 32'd1);
        end
        i_req_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // Randomized traffic: ready jitter, variable latency, redirects, bus errors
        lat_min = 1;
        lat_max = 3;
        rand_err = 1'b1;
        for (int n = 0; n < 600; n++) begin
            i_req_ready  = ($urandom_range(0, 3) != 0);
            i_inst_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 99) < 3) begin
                int mode = $urandom_range(0, 2);
                i_flush_b = (mode != 1);
                i_flush_e = (mode != 0);
                i_flush_addr_b = $urandom;
                i_flush_addr_e = $urandom;
            end
            tick();
            i_flush_b = 1'b0;
            i_flush_e = 1'b0;
        end
        rand_err = 1'b0;
        i_req_ready = 1'b1;
        i_inst_ready = 1'b1;
        repeat (10) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
